interpolate_audio_out: RTL and testbench

- Playback-side counterpart of the capture chain: takes the 24 kHz processed sample stream and produces a 48 kHz stream for the DAC/speaker path.
- Buffers incoming 24 kHz samples in a small FIFO and upsamples 2x by linear interpolation, paced by the 48 kHz audio_trigger.
- Re-applies a DC offset with saturation and reports underflow/overflow.

---
 rtl/interpolate_audio_out_pkg.sv | 33 +++
 rtl/interpolate_audio_out_fifo.sv | 69 ++++++
 rtl/interpolate_audio_out.sv | 176 +++++++++++++++++
 tb/tb_interpolate_audio_out.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interpolate_audio_out_pkg.sv
// Shared audio types, limits and saturation helper for the playback chain.
package interpolate_audio_out_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [SAMPLE_W:0]   wide_t;

    localparam sample_t SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t SAMPLE_MIN = 16'sh8000;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Sign-extend a sample by one bit so sums of two samples cannot wrap.
    function automatic wide_t ext17(input sample_t x);
        return {x[SAMPLE_W-1], x};
    endfunction

    // Clamp a 17-bit intermediate back into the 16-bit sample range.
    function automatic sample_t sat16(input wide_t v);
        if (v > ext17(SAMPLE_MAX)) begin
            return SAMPLE_MAX;
        end else if (v < ext17(SAMPLE_MIN)) begin
            return SAMPLE_MIN;
        end else begin
            return v[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/interpolate_audio_out_fifo.sv
// Small synchronous sample FIFO. A pop in the same cycle frees a slot for a
// push while full; a pop while empty is ignored (no write-through bypass).
module audio_sample_fifo
    import interpolate_audio_out_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     audio_clk,
    input  logic                     rst_in,
    input  logic                     i_push,
    input  sample_t                  i_data,
    input  logic                     i_pop,
    output sample_t                  o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    sample_t        r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_level;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_level == (AW+1)'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    // Storage array; contents are only meaningful below the occupancy mark.
    always_ff @(posedge audio_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

endmodule

// File: rtl/interpolate_audio_out.sv
// 24 kHz -> 48 kHz linear-interpolating playback stage with DC offset,
// saturation and sticky underflow/overflow reporting.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_PRIME | waiting for FIFO to reach PRIME_LEVEL; triggers repeat prev
//   ST_RUN   | phase 0 pops and emits midpoint, phase 1 emits the sample
module interpolate_audio_out
    import interpolate_audio_out_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int PRIME_LEVEL = 2
) (
    input  logic                             audio_clk,
    input  logic                             rst_in,
    input  logic                             audio_trigger,
    input  logic                             sample_valid,
    input  logic signed [15:0]               sample_in,
    input  logic signed [15:0]               offset_in,
    input  logic                             clear_flags,
    output logic signed [15:0]               audio_out,
    output logic                             audio_out_valid,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic                             underflow,
    output logic                             overflow
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_phase;
    logic       w_phase_nxt;
    sample_t    r_prev;
    sample_t    w_prev_nxt;
    sample_t    r_cur;
    sample_t    w_cur_nxt;
    sample_t    r_out;
    sample_t    w_out_nxt;
    logic       r_out_valid;
    logic       w_valid_nxt;
    logic       r_underflow;
    logic       r_overflow;

    logic       w_pop;
    logic       w_underflow_evt;
    logic       w_overflow_evt;
    sample_t    w_head;
    logic       w_full;
    logic       w_empty;
    logic [LVL_W-1:0] w_level;

    wide_t      w_pair_avg;
    wide_t      w_interp_off;
    wide_t      w_prev_off;
    wide_t      w_cur_off;

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .audio_clk (audio_clk),
        .rst_in    (rst_in),
        .i_push    (sample_valid),
        .i_data    (sample_in),
        .i_pop     (w_pop),
        .o_data    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    // Midpoint uses a 17-bit sum and floor shift; result fits in 16 bits
    // so the offset add below also stays within 17 bits.
    assign w_pair_avg   = (ext17(r_prev) + ext17(w_head)) >>> 1;
    assign w_interp_off = w_pair_avg + ext17(offset_in);
    assign w_prev_off   = ext17(r_prev) + ext17(offset_in);
    assign w_cur_off    = ext17(r_cur) + ext17(offset_in);

    // A write while full is dropped unless this cycle's pop frees a slot.
    assign w_overflow_evt = sample_valid && w_full && !w_pop;

    // Next-state, interpolation selection and output value.
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_prev_nxt      = r_prev;
        w_cur_nxt       = r_cur;
        w_out_nxt       = r_out;
        w_valid_nxt     = 1'b0;
        w_pop           = 1'b0;
        w_underflow_evt = 1'b0;

        case (r_state)
            ST_PRIME: begin
                w_phase_nxt = 1'b0;
                if (audio_trigger) begin
                    w_out_nxt   = sat16(w_prev_off);
                    w_valid_nxt = 1'b1;
                end
                if (w_level >= LVL_W'(PRIME_LEVEL)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (audio_trigger) begin
                    w_valid_nxt = 1'b1;
                    if (!r_phase) begin
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_out_nxt   = sat16(w_interp_off);
                            w_cur_nxt   = w_head;
                            w_phase_nxt = 1'b1;
                        end else begin
                            w_out_nxt       = sat16(w_prev_off);
                            w_underflow_evt = 1'b1;
                            w_state_nxt     = ST_PRIME;
                        end
                    end else begin
                        w_out_nxt   = sat16(w_cur_off);
                        w_prev_nxt  = r_cur;
                        w_phase_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_PRIME;
                w_phase_nxt = 1'b0;
            end
        endcase
    end

    // State, history and registered output.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= ST_PRIME;
            r_phase     <= 1'b0;
            r_prev      <= '0;
            r_cur       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_prev      <= w_prev_nxt;
            r_cur       <= w_cur_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_valid_nxt;
        end
    end

    // Sticky flags; a new event outranks a clear in the same cycle.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_underflow_evt) begin
                r_underflow <= 1'b1;
            end else if (clear_flags) begin
                r_underflow <= 1'b0;
            end
            if (w_overflow_evt) begin
                r_overflow <= 1'b1;
            end else if (clear_flags) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign audio_out       = r_out;
    assign audio_out_valid = r_out_valid;
    assign fifo_level      = w_level;
    assign underflow       = r_underflow;
    assign overflow        = r_overflow;

endmodule

// File: tb/tb_interpolate_audio_out.sv
// Self-checking bench: step table plus hand sequences; expected outputs are
// queued on each trigger and compared when audio_out_valid pulses.
module tb_interpolate_audio_out;

    logic               audio_clk = 1'b0;
    logic               rst_in = 1'b1;
    logic               audio_trigger = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic signed [15:0] offset_in = '0;
    logic               clear_flags = 1'b0;
    logic signed [15:0] audio_out;
    logic               audio_out_valid;
    logic [2:0]         fifo_level;
    logic               underflow;
    logic               overflow;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int mon_exp;

    typedef enum {OP_RESET, OP_PUSH, OP_TRIG, OP_OFFS, OP_IDLE, OP_CLR,
                  OP_LVL, OP_UF, OP_OF, OP_DRAIN} op_t;
    typedef struct {
        op_t op;
        int  val;
    } step_t;

    step_t steps[$];
    int a_lo, a_hi;

    interpolate_audio_out #(
        .FIFO_DEPTH  (4),
        .PRIME_LEVEL (2)
    ) dut (
        .audio_clk       (audio_clk),
        .rst_in          (rst_in),
        .audio_trigger   (audio_trigger),
        .sample_valid    (sample_valid),
        .sample_in       (sample_in),
        .offset_in       (offset_in),
        .clear_flags     (clear_flags),
        .audio_out       (audio_out),
        .audio_out_valid (audio_out_valid),
        .fifo_level      (fifo_level),
        .underflow       (underflow),
        .overflow        (overflow)
    );

    always #5 audio_clk = ~audio_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge audio_clk) begin
        if (audio_out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got audio_out=%0d expected no pulse", audio_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("audio_out", int'(audio_out), mon_exp);
            end
        end
    end

    task automatic drive(bit push, int data, bit trig, int exp);
        sample_valid  = push;
        sample_in     = 16'(data);
        audio_trigger = trig;
        if (trig) exp_q.push_back(exp);
        @(posedge audio_clk);
        #1;
        sample_valid  = 1'b0;
        audio_trigger = 1'b0;
        if (trig) check("valid_latency", int'(audio_out_valid), 1);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge audio_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        #1;
        rst_in = 1'b0;
        exp_q.delete();
        #2;
        check("rst_audio_out", int'(audio_out), 0);
        check("rst_valid", int'(audio_out_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_underflow", int'(underflow), 0);
        check("rst_overflow", int'(overflow), 0);
        @(negedge audio_clk);
        rst_in = 1'b1;
        @(posedge audio_clk);
        #1;
    endtask

    task automatic run_steps(int lo, int hi);
        for (int i = lo; i <= hi; i++) begin
            case (steps[i].op)
                OP_RESET: do_reset();
                OP_PUSH:  drive(1'b1, steps[i].val, 1'b0, 0);
                OP_TRIG:  drive(1'b0, 0, 1'b1, steps[i].val);
                OP_OFFS:  offset_in = 16'(steps[i].val);
                OP_IDLE:  idle(steps[i].val);
                OP_CLR: begin
                    clear_flags = 1'b1;
                    idle(1);
                    clear_flags = 1'b0;
                end
                OP_LVL:   check("fifo_level", int'(fifo_level), steps[i].val);
                OP_UF:    check("underflow", int'(underflow), steps[i].val);
                OP_OF:    check("overflow", int'(overflow), steps[i].val);
                OP_DRAIN: begin
                    idle(1);
                    check("pending_outputs", exp_q.size(), 0);
                end
                default: ;
            endcase
        end
    endtask

    function automatic void add(op_t op, int val);
        step_t s;
        s.op  = op;
        s.val = val;
        steps.push_back(s);
    endfunction

    initial begin
        int ovf_exp[9];
        ovf_exp = '{0, 1, 1, 2, 2, 3, 3, 4, 4};

        // prime/start
        a_lo = steps.size();
        add(OP_RESET, 0);   add(OP_OFFS, 0);
        add(OP_TRIG, 0);    add(OP_TRIG, 0);
        add(OP_PUSH, 100);  add(OP_LVL, 1);  add(OP_TRIG, 0);
        add(OP_PUSH, 200);  add(OP_LVL, 2);  add(OP_IDLE, 1);
        add(OP_TRIG, 50);   add(OP_TRIG, 100);
        add(OP_TRIG, 150);  add(OP_TRIG, 200);
        add(OP_UF, 0);      add(OP_LVL, 0);
        add(OP_TRIG, 200);  add(OP_UF, 1);   add(OP_DRAIN, 0);
        a_hi = steps.size() - 1;
        // negative rounding
        add(OP_RESET, 0);   add(OP_OFFS, 0);
        add(OP_PUSH, -3);   add(OP_PUSH, -6); add(OP_IDLE, 1);
        add(OP_TRIG, -2);   add(OP_TRIG, -3);
        add(OP_TRIG, -5);   add(OP_TRIG, -6);
        add(OP_TRIG, -6);   add(OP_UF, 1);
        add(OP_CLR, 0);     add(OP_UF, 0);   add(OP_DRAIN, 0);
        // saturation both rails
        add(OP_RESET, 0);   add(OP_OFFS, 1000);
        add(OP_TRIG, 1000);
        add(OP_PUSH, 32000); add(OP_PUSH, 32000); add(OP_IDLE, 1);
        add(OP_TRIG, 17000); add(OP_TRIG, 32767);
        add(OP_TRIG, 32767); add(OP_TRIG, 32767);
        add(OP_OFFS, -1000);
        add(OP_PUSH, -32768); add(OP_PUSH, -32768); add(OP_IDLE, 1);
        add(OP_TRIG, -1384);  add(OP_TRIG, -32768);
        add(OP_TRIG, -32768); add(OP_TRIG, -32768);
        add(OP_UF, 0);        add(OP_DRAIN, 0);

        run_steps(0, steps.size() - 1);

        // overflow, clear racing a new event, fifth sample lost
        do_reset();
        offset_in = '0;
        for (int i = 1; i <= 5; i++) drive(1'b1, i, 1'b0, 0);
        check("ovf_level", int'(fifo_level), 4);
        check("ovf_flag", int'(overflow), 1);
        clear_flags = 1'b1;
        drive(1'b1, 99, 1'b0, 0);
        clear_flags = 1'b0;
        check("ovf_clear_race", int'(overflow), 1);
        check("ovf_level_race", int'(fifo_level), 4);
        clear_flags = 1'b1;
        idle(1);
        clear_flags = 1'b0;
        check("ovf_cleared", int'(overflow), 0);
        for (int i = 0; i < 9; i++) drive(1'b0, 0, 1'b1, ovf_exp[i]);
        check("ovf_underflow", int'(underflow), 1);
        idle(1);
        check("ovf_pending", exp_q.size(), 0);

        // push and pop together while full
        do_reset();
        for (int i = 1; i <= 4; i++) drive(1'b1, i * 10, 1'b0, 0);
        idle(1);
        check("full_level_pre", int'(fifo_level), 4);
        drive(1'b1, 50, 1'b1, 5);
        check("full_level_post", int'(fifo_level), 4);
        check("full_no_overflow", int'(overflow), 0);
        drive(1'b0, 0, 1'b1, 10);
        drive(1'b0, 0, 1'b1, 15);
        drive(1'b0, 0, 1'b1, 20);
        check("full_level_drain", int'(fifo_level), 3);
        idle(1);
        check("full_pending", exp_q.size(), 0);

        // push and pop together while empty
        do_reset();
        drive(1'b1, 7, 1'b0, 0);
        drive(1'b1, 8, 1'b0, 0);
        idle(1);
        drive(1'b0, 0, 1'b1, 3);
        drive(1'b0, 0, 1'b1, 7);
        drive(1'b0, 0, 1'b1, 7);
        drive(1'b0, 0, 1'b1, 8);
        check("empty_level_pre", int'(fifo_level), 0);
        drive(1'b1, 9, 1'b1, 8);
        check("empty_underflow", int'(underflow), 1);
        check("empty_level_post", int'(fifo_level), 1);
        check("empty_no_overflow", int'(overflow), 0);
        idle(1);
        check("empty_pending", exp_q.size(), 0);

        // asynchronous reset in the middle of RUN
        do_reset();
        drive(1'b1, 100, 1'b0, 0);
        drive(1'b1, 200, 1'b0, 0);
        idle(1);
        drive(1'b0, 0, 1'b1, 50);
        @(negedge audio_clk);
        #2;
        check("mid_pending", exp_q.size(), 0);
        check("mid_out_before", int'(audio_out), 50);
        rst_in = 1'b0;
        #1;
        check("mid_rst_out", int'(audio_out), 0);
        check("mid_rst_valid", int'(audio_out_valid), 0);
        check("mid_rst_level", int'(fifo_level), 0);
        @(negedge audio_clk);
        rst_in = 1'b1;
        @(posedge audio_clk);
        #1;
        run_steps(a_lo + 1, a_hi);

        idle(2);
        check("final_pending", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
